csr_trap_sequencer: RTL and testbench

//  Sole owner of the CSR file write port. Arbitrates between WBU CSR-instruction writes and

---
 rtl/csr_trap_sequencer_pkg.sv | 31 +++
 rtl/csr_trap_sequencer_if.sv | 51 +++++
 rtl/csr_mstatus_update.sv | 30 +++
 rtl/csr_trap_sequencer.sv | 140 ++++++++++++++
 tb/tb_csr_trap_sequencer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_trap_sequencer_pkg.sv
// Shared definitions for the CSR trap sequencer:
// CSR addresses, mstatus fields, trap kinds, FSM states.
package csr_trap_sequencer_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [1:0] {
    TRAP_RSVD0 = 2'b00,
    TRAP_ECALL = 2'b01,
    TRAP_MRET  = 2'b10,
    TRAP_RSVD3 = 2'b11
  } trap_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INSN_WR  = 3'd1,
    ST_EPC_WR   = 3'd2,
    ST_CAUSE_WR = 3'd3,
    ST_STAT_WR  = 3'd4,
    ST_REDIR    = 3'd5
  } state_e;

endpackage

// File: rtl/csr_trap_sequencer_if.sv
// Request, CSR-file and redirect signals around the
// trap sequencer; slave is the sequencer side.
interface csr_trap_sequencer_if #(
  parameter int XLEN = 32
);

  logic            insn_valid;
  logic            insn_ready;
  logic [11:0]     insn_addr;
  logic [XLEN-1:0] insn_wdata;
  logic            insn_wen;

  logic            trap_valid;
  logic            trap_ready;
  logic [1:0]      trap_kind;
  logic [XLEN-1:0] trap_pc;

  logic [XLEN-1:0] csr_mstatus;
  logic [XLEN-1:0] csr_mepc;
  logic [XLEN-1:0] csr_mtvec;

  logic            csr_wvalid;
  logic            csr_wready;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;

  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output insn_valid, insn_addr, insn_wdata, insn_wen,
    output trap_valid, trap_kind, trap_pc,
    output csr_mstatus, csr_mepc, csr_mtvec,
    output csr_wready, redirect_ready,
    input  insn_ready, trap_ready,
    input  csr_wvalid, csr_waddr, csr_wdata,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  insn_valid, insn_addr, insn_wdata, insn_wen,
    input  trap_valid, trap_kind, trap_pc,
    input  csr_mstatus, csr_mepc, csr_mtvec,
    input  csr_wready, redirect_ready,
    output insn_ready, trap_ready,
    output csr_wvalid, csr_waddr, csr_wdata,
    output redirect_valid, redirect_pc
  );

endinterface

// File: rtl/csr_mstatus_update.sv
// mstatus rewrite on trap entry (ecall) and
// trap return (mret); other kinds pass through.
module csr_mstatus_update
  import csr_trap_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  trap_kind_e      kind,
  input  logic [XLEN-1:0] old_val,
  output logic [XLEN-1:0] new_val
);

  always_comb begin
    new_val = old_val;
    unique case (1'b1)
      (kind == TRAP_ECALL): begin
        new_val[MSTATUS_MPIE] = old_val[MSTATUS_MIE];
        new_val[MSTATUS_MIE]  = 1'b0;
        new_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      (kind == TRAP_MRET): begin
        new_val[MSTATUS_MIE]  = old_val[MSTATUS_MPIE];
        new_val[MSTATUS_MPIE] = 1'b1;
        new_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_trap_sequencer.sv
// Owns the CSR write port: serialises CSR-insn writes
// and ecall/mret write sequences, then redirects the PC.
module csr_trap_sequencer
  import csr_trap_sequencer_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(32'hb)
) (
  input  logic                 clk,
  input  logic                 rst,
  csr_trap_sequencer_if.slave  bus,
  output logic                 busy
);

  state_e          state;
  state_e          state_n;

  logic [11:0]     s_addr;
  logic [XLEN-1:0] s_wdata;
  trap_kind_e      s_kind;
  logic [XLEN-1:0] s_pc;
  logic [XLEN-1:0] s_mstatus;
  logic [XLEN-1:0] s_mepc;
  logic [XLEN-1:0] s_mtvec;
  logic [XLEN-1:0] new_mstatus;

  logic            idle;
  logic            trap_fire;
  logic            insn_fire;
  trap_kind_e      kind_in;

  assign kind_in = trap_kind_e'(bus.trap_kind);
  assign idle    = (state == ST_IDLE);
  assign busy    = ~idle;

  // trap requests take priority over a coincident insn write
  assign bus.trap_ready = idle;
  assign bus.insn_ready = idle & ~bus.trap_valid;

  assign trap_fire = bus.trap_valid & bus.trap_ready;
  assign insn_fire = bus.insn_valid & bus.insn_ready;

  csr_mstatus_update #(
    .XLEN (XLEN)
  ) u_mstatus_update (
    .kind    (s_kind),
    .old_val (s_mstatus),
    .new_val (new_mstatus)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_addr    <= '0;
      s_wdata   <= '0;
      s_kind    <= TRAP_RSVD0;
      s_pc      <= '0;
      s_mstatus <= '0;
      s_mepc    <= '0;
      s_mtvec   <= '0;
    end else begin
      if (trap_fire) begin
        s_kind <= kind_in;
        s_pc   <= bus.trap_pc;
      end
      if (insn_fire) begin
        s_addr  <= bus.insn_addr;
        s_wdata <= bus.insn_wdata;
      end
      if (trap_fire || insn_fire) begin
        s_mstatus <= bus.csr_mstatus;
        s_mepc    <= bus.csr_mepc;
        s_mtvec   <= bus.csr_mtvec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // outputs come only from state and the snapshot
  always_comb begin
    state_n            = state;
    bus.csr_wvalid     = 1'b0;
    bus.csr_waddr      = '0;
    bus.csr_wdata      = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    unique case (state)
      ST_IDLE: begin
        if (trap_fire) begin
          unique case (1'b1)
            (kind_in == TRAP_ECALL): state_n = ST_EPC_WR;
            (kind_in == TRAP_MRET):  state_n = ST_STAT_WR;
            default:                 state_n = ST_IDLE;
          endcase
        end else if (insn_fire && bus.insn_wen) begin
          state_n = ST_INSN_WR;
        end
      end
      ST_INSN_WR: begin
        bus.csr_wvalid = 1'b1;
        bus.csr_waddr  = s_addr;
        bus.csr_wdata  = s_wdata;
        if (bus.csr_wready) state_n = ST_IDLE;
      end
      ST_EPC_WR: begin
        bus.csr_wvalid = 1'b1;
        bus.csr_waddr  = CSR_MEPC;
        bus.csr_wdata  = s_pc;
        if (bus.csr_wready) state_n = ST_CAUSE_WR;
      end
      ST_CAUSE_WR: begin
        bus.csr_wvalid = 1'b1;
        bus.csr_waddr  = CSR_MCAUSE;
        bus.csr_wdata  = ECALL_CAUSE;
        if (bus.csr_wready) state_n = ST_STAT_WR;
      end
      ST_STAT_WR: begin
        bus.csr_wvalid = 1'b1;
        bus.csr_waddr  = CSR_MSTATUS;
        bus.csr_wdata  = new_mstatus;
        if (bus.csr_wready) state_n = ST_REDIR;
      end
      ST_REDIR: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = (s_kind == TRAP_ECALL) ?
                             {s_mtvec[XLEN-1:2], 2'b00} :
                             s_mepc;
        if (bus.redirect_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed bench for csr_trap_sequencer: insn writes,
// ecall/mret sequences, arbitration, stalls, reset abort.
module tb_csr_trap_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_checks = 0;
  int   n_errs   = 0;

  csr_trap_sequencer_if #(.XLEN(32)) bus ();

  csr_trap_sequencer #(
    .XLEN        (32),
    .ECALL_CAUSE (32'hb)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag,
                        input logic [11:0] a,
                        input logic [31:0] d);
    check({tag, ".wvalid"}, bus.csr_wvalid, 1);
    check({tag, ".waddr"}, bus.csr_waddr, a);
    check({tag, ".wdata"}, bus.csr_wdata, d);
    check({tag, ".rvalid"}, bus.redirect_valid, 0);
  endtask

  task automatic chk_redir(input string tag,
                           input logic [31:0] pc);
    check({tag, ".rvalid"}, bus.redirect_valid, 1);
    check({tag, ".rpc"}, bus.redirect_pc, pc);
    check({tag, ".wvalid"}, bus.csr_wvalid, 0);
  endtask

  task automatic chk_idle(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".wvalid"}, bus.csr_wvalid, 0);
    check({tag, ".rvalid"}, bus.redirect_valid, 0);
  endtask

  task automatic ecall(input logic [31:0] pc,
                       input logic [31:0] ms,
                       input logic [31:0] tv);
    bus.trap_valid  = 1'b1;
    bus.trap_kind   = 2'b01;
    bus.trap_pc     = pc;
    bus.csr_mstatus = ms;
    bus.csr_mtvec   = tv;
  endtask

  initial begin
    rst                = 1'b0;
    bus.insn_valid     = 1'b0;
    bus.insn_addr      = '0;
    bus.insn_wdata     = '0;
    bus.insn_wen       = 1'b0;
    bus.trap_valid     = 1'b0;
    bus.trap_kind      = 2'b00;
    bus.trap_pc        = '0;
    bus.csr_mstatus    = '0;
    bus.csr_mepc       = '0;
    bus.csr_mtvec      = '0;
    bus.csr_wready     = 1'b1;
    bus.redirect_ready = 1'b1;

    repeat (2) step();
    chk_idle("rst");
    check("rst.waddr", bus.csr_waddr, 0);
    check("rst.wdata", bus.csr_wdata, 0);
    check("rst.rpc", bus.redirect_pc, 0);
    check("rst.insn_ready", bus.insn_ready, 1);
    check("rst.trap_ready", bus.trap_ready, 1);
    rst = 1'b1;
    step();

    // CSR instruction write
    bus.insn_valid = 1'b1;
    bus.insn_addr  = 12'h305;
    bus.insn_wdata = 32'h8000_0100;
    bus.insn_wen   = 1'b1;
    #1;
    check("iw.insn_ready", bus.insn_ready, 1);
    step();
    bus.insn_valid = 1'b0;
    bus.insn_wdata = 32'hdead_beef;
    chk_wr("iw", 12'h305, 32'h8000_0100);
    check("iw.busy", busy, 1);
    check("iw.insn_ready_busy", bus.insn_ready, 0);
    step();
    chk_idle("iw.done");

    // read-only insn: consumed without a write
    bus.insn_valid = 1'b1;
    bus.insn_wen   = 1'b0;
    step();
    bus.insn_valid = 1'b0;
    chk_idle("ro");

    // ecall, inputs scrambled after accept
    ecall(32'h8000_0040, 32'h8, 32'h8000_0101);
    step();
    bus.trap_valid  = 1'b0;
    bus.trap_pc     = 32'h1111_1111;
    bus.csr_mstatus = 32'hffff_ffff;
    bus.csr_mtvec   = 32'h2222_2222;
    chk_wr("ec.epc", 12'h341, 32'h8000_0040);
    step();
    chk_wr("ec.cause", 12'h342, 32'hb);
    step();
    chk_wr("ec.stat", 12'h300, 32'h1880);
    step();
    chk_redir("ec.redir", 32'h8000_0100);
    step();
    chk_idle("ec.done");

    // mret
    bus.trap_valid  = 1'b1;
    bus.trap_kind   = 2'b10;
    bus.csr_mstatus = 32'h1880;
    bus.csr_mepc    = 32'h8000_0044;
    step();
    bus.trap_valid = 1'b0;
    bus.csr_mepc   = 32'h3333_3333;
    chk_wr("mr.stat", 12'h300, 32'h1888);
    step();
    chk_redir("mr.redir", 32'h8000_0044);
    step();
    chk_idle("mr.done");

    // reserved kind dropped
    bus.trap_valid = 1'b1;
    bus.trap_kind  = 2'b11;
    step();
    bus.trap_valid = 1'b0;
    chk_idle("rsvd");

    // trap and insn together: trap first
    ecall(32'h8000_0200, 32'h0, 32'h8000_0400);
    bus.insn_valid = 1'b1;
    bus.insn_addr  = 12'h340;
    bus.insn_wdata = 32'h0000_abcd;
    bus.insn_wen   = 1'b1;
    #1;
    check("arb.insn_ready", bus.insn_ready, 0);
    check("arb.trap_ready", bus.trap_ready, 1);
    step();
    bus.trap_valid = 1'b0;
    chk_wr("arb.epc", 12'h341, 32'h8000_0200);
    check("arb.ir1", bus.insn_ready, 0);
    step();
    chk_wr("arb.cause", 12'h342, 32'hb);
    step();
    chk_wr("arb.stat", 12'h300, 32'h1800);
    check("arb.ir3", bus.insn_ready, 0);
    step();
    chk_redir("arb.redir", 32'h8000_0400);
    check("arb.ir4", bus.insn_ready, 0);
    step();
    check("arb.ir_idle", bus.insn_ready, 1);
    step();
    bus.insn_valid = 1'b0;
    chk_wr("arb.iw", 12'h340, 32'h0000_abcd);
    step();
    chk_idle("arb.done");

    // write and redirect back-pressure
    ecall(32'h8000_0300, 32'h88, 32'h8000_0503);
    step();
    bus.trap_valid = 1'b0;
    chk_wr("st.epc", 12'h341, 32'h8000_0300);
    step();
    bus.csr_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_wr($sformatf("st.cause%0d", i), 12'h342, 32'hb);
      step();
    end
    chk_wr("st.cause3", 12'h342, 32'hb);
    bus.csr_wready = 1'b1;
    step();
    chk_wr("st.stat", 12'h300, 32'h1880);
    step();
    bus.redirect_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk_redir($sformatf("st.redir%0d", i), 32'h8000_0500);
      step();
    end
    chk_redir("st.redir2", 32'h8000_0500);
    bus.redirect_ready = 1'b1;
    step();
    chk_idle("st.done");

    // reset during STAT_WR aborts the sequence
    bus.trap_valid  = 1'b1;
    bus.trap_kind   = 2'b10;
    bus.csr_mstatus = 32'h80;
    bus.csr_mepc    = 32'h8000_0600;
    step();
    bus.trap_valid = 1'b0;
    bus.csr_wready = 1'b0;
    chk_wr("ra.stat", 12'h300, 32'h1888);
    rst = 1'b0;
    #1;
    chk_idle("ra.in_rst");
    check("ra.waddr", bus.csr_waddr, 0);
    check("ra.wdata", bus.csr_wdata, 0);
    step();
    rst = 1'b1;
    bus.csr_wready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle($sformatf("ra.after%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errs);
    $finish;
  end

endmodule
